// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_DATA_W = 32;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath on {acc,q}: add-shift-right for multiply,
// restoring subtract-shift-left for divide (m is the multiplicand or divisor magnitude).
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] m_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] rem_s;
  logic [DATA_W:0] diff_s;

  // acc < m is invariant for divide, so the borrow bit alone decides restore vs. keep
  always_comb begin
    sum_s  = {1'b0, acc_i} + {1'b0, m_i};
    rem_s  = {acc_i, q_i[DATA_W-1]};
    diff_s = rem_s - {1'b0, m_i};
    if (is_div_i) begin
      if (!diff_s[DATA_W]) begin
        acc_o = diff_s[DATA_W-1:0];
        q_o   = {q_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_o = rem_s[DATA_W-1:0];
        q_o   = {q_i[DATA_W-2:0], 1'b0};
      end
    end else if (q_i[0]) begin
      {acc_o, q_o} = {sum_s, q_i[DATA_W-1:1]};
    end else begin
      {acc_o, q_o} = {1'b0, acc_i, q_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer and HI/LO owner. Optional divide-by-zero trap is
// enabled by defining MULDIV_DIV0_TRAP_EN (adds the div0 output).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              op_mult,
  input  logic              op_multu,
  input  logic              op_div,
  input  logic              op_divu,
  input  logic              op_mfhi,
  input  logic              op_mflo,
  input  logic              op_mthi,
  input  logic              op_mtlo,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
`ifdef MULDIV_DIV0_TRAP_EN
  ,
  output logic              div0
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
`ifdef MULDIV_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  md_state_e           state_q, state_d;
  md_op_e              op_q, op_d, op_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d, mq_q, mq_d, mag_q, mag_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d, zdiv_q, zdiv_d;
  logic                done_q, done_d;
`ifdef MULDIV_DIV0_TRAP_EN
  logic                div0_q, div0_d;
`endif
  logic                start_s, any_op_s, is_sgn_s, rt_zero_s;
  logic [DATA_W-1:0]   rs_mag_s, rt_mag_s, step_acc_s, step_q_s, quo_s, rem_s;
  logic [2*DATA_W-1:0] prod_s;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div_i (md_is_div(op_q)),
    .acc_i    (acc_q),
    .q_i      (mq_q),
    .m_i      (mag_q),
    .acc_o    (step_acc_s),
    .q_o      (step_q_s)
  );

  // Decode the incoming strobes and take operand magnitudes for signed ops
  always_comb begin
    if (op_mult)       op_s = MD_MULT;
    else if (op_multu) op_s = MD_MULTU;
    else if (op_div)   op_s = MD_DIV;
    else               op_s = MD_DIVU;
    start_s   = issue & (op_mult | op_multu | op_div | op_divu) & ~flush;
    any_op_s  = op_mult | op_multu | op_div | op_divu | op_mfhi | op_mflo | op_mthi | op_mtlo;
    is_sgn_s  = md_is_signed(op_s);
    rt_zero_s = (rt_data == {DATA_W{1'b0}});
    rs_mag_s  = (is_sgn_s && rs_data[DATA_W-1]) ? ({DATA_W{1'b0}} - rs_data) : rs_data;
    rt_mag_s  = (is_sgn_s && rt_data[DATA_W-1]) ? ({DATA_W{1'b0}} - rt_data) : rt_data;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          if (TRAP_EN && md_is_div(op_s) && rt_zero_s) state_d = DONE;
          else                                         state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (flush)                                    state_d = IDLE;
        else if (cnt_q == CNT_W'(DATA_W - 1))         state_d = DONE;
        else                                          state_d = CALC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stall holds back every mul/div/HI/LO instruction until IDLE
  always_comb begin
    busy  = (state_q != IDLE);
    stall = busy & issue & any_op_s;
    rdata = op_mfhi ? hi_q : lo_q;
  end

  // Sign fixup of the finished magnitudes
  always_comb begin
    prod_s = {acc_q, mq_q};
    if (a_neg_q ^ b_neg_q) prod_s = {(2*DATA_W){1'b0}} - prod_s;
    else                   prod_s = {acc_q, mq_q};
    quo_s = (a_neg_q ^ b_neg_q) ? ({DATA_W{1'b0}} - mq_q) : mq_q;
    rem_s = a_neg_q ? ({DATA_W{1'b0}} - acc_q) : acc_q;
  end

  // Datapath next state: operand latch, iteration, HI/LO writes
  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mag_d   = mag_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    zdiv_d  = zdiv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
    div0_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_s) begin
          op_d    = op_s;
          cnt_d   = {CNT_W{1'b0}};
          acc_d   = {DATA_W{1'b0}};
          mq_d    = md_is_div(op_s) ? rs_mag_s : rt_mag_s;
          mag_d   = md_is_div(op_s) ? rt_mag_s : rs_mag_s;
          a_neg_d = is_sgn_s & rs_data[DATA_W-1];
          b_neg_d = is_sgn_s & rt_data[DATA_W-1];
          zdiv_d  = md_is_div(op_s) & rt_zero_s;
        end else if (issue && !flush) begin
          if (op_mthi) hi_d = rs_data;
          else         hi_d = hi_q;
          if (op_mtlo) lo_d = rs_data;
          else         lo_d = lo_q;
        end else begin
          hi_d = hi_q;
        end
      end
      CALC: begin
        acc_d = step_acc_s;
        mq_d  = step_q_s;
        cnt_d = (cnt_q == CNT_W'(DATA_W - 1)) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
      end
      DONE: begin
        if (!flush) begin
          done_d = 1'b1;
          if (TRAP_EN && zdiv_q) begin
`ifdef MULDIV_DIV0_TRAP_EN
            div0_d = 1'b1;
`endif
            hi_d = hi_q;
          end else if (md_is_div(op_q)) begin
            hi_d = rem_s;
            lo_d = zdiv_q ? {DATA_W{1'b1}} : quo_s;
          end else begin
            hi_d = prod_s[2*DATA_W-1:DATA_W];
            lo_d = prod_s[DATA_W-1:0];
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset abandons any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= MD_MULT;
      cnt_q   <= {CNT_W{1'b0}};
      acc_q   <= {DATA_W{1'b0}};
      mq_q    <= {DATA_W{1'b0}};
      mag_q   <= {DATA_W{1'b0}};
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      zdiv_q  <= 1'b0;
      hi_q    <= {DATA_W{1'b0}};
      lo_q    <= {DATA_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mag_q   <= mag_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      zdiv_q  <= zdiv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef MULDIV_DIV0_TRAP_EN
  // Divide-by-zero flag, pulses together with done
  always_ff @(posedge clk) begin
    if (rst) div0_q <= 1'b0;
    else     div0_q <= div0_d;
  end
  assign div0 = div0_q;
`endif

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of mul/div vectors plus hand sequences
// for stall, flush, reset, HI/LO moves and divide-by-zero.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, issue, flush;
  logic         op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic [W-1:0] rs_data, rt_data, rdata, hi, lo;
  logic         stall, busy, done;
`ifdef MULDIV_DIV0_TRAP_EN
  logic         div0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    int           op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs[9];

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .issue(issue),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mfhi(op_mfhi), .op_mflo(op_mflo), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .flush(flush), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .busy(busy), .done(done), .rdata(rdata), .hi(hi), .lo(lo)
`ifdef MULDIV_DIV0_TRAP_EN
    , .div0(div0)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear();
    issue = 1'b0; flush = 1'b0;
    op_mult = 1'b0; op_multu = 1'b0; op_div = 1'b0; op_divu = 1'b0;
    op_mfhi = 1'b0; op_mflo = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0;
  endtask

  task automatic issue_md(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    clear();
    issue = 1'b1;
    op_mult = (op == 0); op_multu = (op == 1); op_div = (op == 2); op_divu = (op == 3);
    rs_data = a; rt_data = b;
  endtask

  task automatic move_to(input bit to_hi, input logic [W-1:0] v);
    clear();
    issue = 1'b1; op_mthi = to_hi; op_mtlo = ~to_hi; rs_data = v;
    tick();
    clear();
  endtask

  // Full-length op: accept at edge T, results and done visible after edge T+33
  task automatic run_vec(input string nm, input int op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    issue_md(op, a, b);
    tick();
    clear();
    rs_data = 32'hDEAD_BEEF; rt_data = 32'h0BAD_F00D;
    chk({nm, "_busy"}, busy, 64'd1);
    for (int i = 0; i < 32; i++) tick();
    chk({nm, "_early_done"}, done, 64'd0);
    tick();
    chk({nm, "_done"}, done, 64'd1);
    chk({nm, "_hi"}, hi, {32'd0, ehi});
    chk({nm, "_lo"}, lo, {32'd0, elo});
    chk({nm, "_idle"}, busy, 64'd0);
    tick();
    chk({nm, "_done_pulse"}, done, 64'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[6] = '{2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[8] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    clear();
    rs_data = '0; rt_data = '0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_hi", hi, 64'd0);
    chk("rst_lo", lo, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_stall", stall, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ehi, vecs[i].elo);

    // mflo issued one cycle after a mult accept stalls until IDLE
    issue_md(0, 32'd3, 32'd5);
    tick();
    clear();
    issue = 1'b1; op_mflo = 1'b1;
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      tick();
    end
    chk("mflo_stall_cycles", n, 64'd33);
    chk("mflo_rdata", rdata, 64'd15);
    clear();
    tick();

    // flush at cnt=10 leaves HI/LO untouched and never raises done
    move_to(1'b1, 32'h5);
    move_to(1'b0, 32'h5);
    issue_md(0, 32'd2, 32'd3);
    tick();
    clear();
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 64'd0);
    chk("flush_hi", hi, 64'd5);
    chk("flush_lo", lo, 64'd5);
    n = 0;
    for (int i = 0; i < 35; i++) begin
      if (done) n++;
      tick();
    end
    chk("flush_no_done", n, 64'd0);
    run_vec("after_flush", 0, 32'd2, 32'd3, 32'd0, 32'd6);

    // flush together with a start wins
    issue_md(0, 32'd2, 32'd3);
    flush = 1'b1;
    tick();
    clear();
    chk("flush_start_busy", busy, 64'd0);

    // mtlo in the done cycle keeps the freshly written HI
    issue_md(1, 32'hFFFF_FFFF, 32'd2);
    tick();
    clear();
    for (int i = 0; i < 33; i++) tick();
    chk("done_cycle", done, 64'd1);
    issue = 1'b1; op_mtlo = 1'b1; rs_data = 32'hAA;
    #1;
    chk("mtlo_no_stall", stall, 64'd0);
    tick();
    clear();
    chk("mtlo_done_lo", lo, 64'hAA);
    chk("mtlo_done_hi", hi, 64'd1);

    // divide by zero
`ifdef MULDIV_DIV0_TRAP_EN
    move_to(1'b1, 32'h11);
    move_to(1'b0, 32'h22);
    issue_md(3, 32'd5, 32'd0);
    tick();
    clear();
    chk("dz_busy", busy, 64'd1);
    chk("dz_early", done, 64'd0);
    tick();
    chk("dz_done", done, 64'd1);
    chk("dz_div0", div0, 64'd1);
    chk("dz_hi", hi, 64'h11);
    chk("dz_lo", lo, 64'h22);
    tick();
    chk("dz_div0_pulse", div0, 64'd0);
`else
    run_vec("divu_zero", 3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_vec("div_zero", 2, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
`endif

    // reset at cnt=20 abandons the op and clears HI/LO
    move_to(1'b1, 32'h77);
    issue_md(0, 32'd9, 32'd9);
    tick();
    clear();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_hi", hi, 64'd0);
    chk("midrst_lo", lo, 64'd0);
    chk("midrst_busy", busy, 64'd0);
    chk("midrst_done", done, 64'd0);

    // mthi in IDLE
    issue = 1'b1; op_mthi = 1'b1; rs_data = 32'h1234;
    #1;
    chk("mthi_stall", stall, 64'd0);
    tick();
    clear();
    chk("mthi_hi", hi, 64'h1234);
    op_mfhi = 1'b1;
    #1;
    chk("mfhi_rdata", rdata, 64'h1234);
    clear();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
